// File: rtl/dac_sample_sched_pkg.sv
// Shared definitions for the DAC sample scheduler.
//   state_t          : scheduler states (IDLE, PRIME, RUN)
//   default_idle_val : mid-scale code for a given sample width
//   level_width      : width of a FIFO occupancy count for a given address width
package dac_sample_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    function automatic logic [31:0] default_idle_val(input int bits);
        return 32'd1 << (bits - 1);
    endfunction

    // One extra bit so a completely full FIFO (2^aw entries) is representable.
    function automatic int level_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/dac_sample_sched_fifo.sv
// Synchronous FIFO used as the sample buffer.
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write a word (caller guarantees !full)
//   pop/rdata  : rdata shows the head; pop advances past it (ignored when empty)
//   flush      : clears pointers and level; overrides push and pop
//   level      : occupancy 0..2^AW; full/empty derived from it
module sched_fifo
    import dac_sample_sched_pkg::*;
#(
    parameter int W  = 16,
    parameter int AW = 4,
    localparam int LW = level_width(AW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // Storage left without reset so it can map onto a RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_sched.sv
// Sample scheduler for the hybrid R2R+PWM DAC.
//   clk, rst_n               : clock, async active-low reset
//   enable                   : 1 = play buffered samples, 0 = mid-scale idle
//   flush                    : pulse, empties the sample FIFO
//   s_valid/s_ready/s_data   : producer push port
//   val_req                  : per-frame request from the DAC core
//   dac_val                  : registered sample the DAC captures at the next val_req
//   running                  : high while in RUN
//   underrun/underrun_cnt    : per-event pulse and saturating event count
//   fifo_level               : FIFO occupancy
//
// state | meaning
// IDLE  | not playing; dac_val forced to IDLE_VAL at each val_req
// PRIME | waiting for fifo_level >= PREFILL; dac_val held
// RUN   | one pop per val_req; empty FIFO at val_req is an underrun
module dac_sample_sched
    import dac_sample_sched_pkg::*;
#(
    parameter int                  DAC_BITS = 16,
    parameter int                  FIFO_AW  = 4,
    parameter int                  PREFILL  = 8,
    parameter logic [DAC_BITS-1:0] IDLE_VAL = DAC_BITS'(default_idle_val(DAC_BITS)),
    localparam int                 LEVEL_W  = level_width(FIFO_AW)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                flush,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DAC_BITS-1:0] s_data,
    input  logic                val_req,
    output logic [DAC_BITS-1:0] dac_val,
    output logic                running,
    output logic                underrun,
    output logic [15:0]         underrun_cnt,
    output logic [LEVEL_W-1:0]  fifo_level
);

    state_t                state;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [DAC_BITS-1:0]   head;

    assign s_ready = !fifo_full && !flush;
    assign push    = s_valid && s_ready;
    // Disable takes priority over a coincident request, so that request is not served.
    assign pop     = (state == ST_RUN) && enable && val_req && !fifo_empty;

    sched_fifo #(
        .W  (DAC_BITS),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (s_data),
        .rdata (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dac_val      <= IDLE_VAL;
            running      <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (val_req) begin
                        dac_val <= IDLE_VAL;
                    end
                    if (enable) begin
                        state <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (fifo_level >= LEVEL_W'(PREFILL)) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        // Output only returns to mid-scale at the next frame boundary.
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end else if (val_req) begin
                        if (!fifo_empty) begin
                            dac_val <= head;
                        end else begin
                            underrun <= 1'b1;
                            if (underrun_cnt != 16'hFFFF) begin
                                underrun_cnt <= underrun_cnt + 1'b1;
                            end
                            state   <= ST_PRIME;
                            running <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sample_sched.sv
module tb_dac_sample_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        val_req;
    logic [15:0] dac_val;
    logic        running;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic [4:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    dac_sample_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .val_req      (val_req),
        .dac_val      (dac_val),
        .running      (running),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic req();
        val_req = 1'b1;
        tick();
        val_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; flush = 1'b0; s_valid = 1'b0;
        s_data = '0; val_req = 1'b0;
        tick();
        total++; if (dac_val !== 16'h8000) begin bad++; $display("FAIL reset_dac_val got=%h exp=8000", dac_val); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", underrun_cnt); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_enable_no_data();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            req();
            total++; if (dac_val !== 16'h8000) begin bad++; $display("FAIL nodata_dac_val[%0d] got=%h exp=8000", i, dac_val); end
            total++; if (running !== 1'b0) begin bad++; $display("FAIL nodata_running[%0d] got=%b exp=0", i, running); end
            total++; if (underrun !== 1'b0) begin bad++; $display("FAIL nodata_underrun[%0d] got=%b exp=0", i, underrun); end
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_prime_run();
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        total++; if (fifo_level !== 5'd8) begin bad++; $display("FAIL prime_level got=%0d exp=8", fifo_level); end
        enable = 1'b1;
        tick();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL prime_running_early got=%b exp=0", running); end
        tick();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL prime_running got=%b exp=1", running); end
        for (int i = 1; i <= 8; i++) begin
            req();
            total++; if (dac_val !== 16'(i)) begin bad++; $display("FAIL run_pop_val[%0d] got=%h exp=%h", i, dac_val, 16'(i)); end
            total++; if (fifo_level !== 5'(8 - i)) begin bad++; $display("FAIL run_pop_level[%0d] got=%0d exp=%0d", i, fifo_level, 8 - i); end
            total++; if (underrun !== 1'b0) begin bad++; $display("FAIL run_pop_underrun[%0d] got=%b exp=0", i, underrun); end
        end
    endtask

    task automatic test_underrun();
        req();
        total++; if (dac_val !== 16'h0008) begin bad++; $display("FAIL ur_hold got=%h exp=0008", dac_val); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_pulse got=%b exp=1", underrun); end
        total++; if (underrun_cnt !== 16'd1) begin bad++; $display("FAIL ur_cnt got=%0d exp=1", underrun_cnt); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL ur_running got=%b exp=0", running); end
        tick();
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_pulse_len got=%b exp=0", underrun); end
        for (int i = 0; i < 8; i++) push_word(16'h0011 + 16'(i));
        tick();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL ur_resume got=%b exp=1", running); end
        req();
        total++; if (dac_val !== 16'h0011) begin bad++; $display("FAIL ur_resume_val got=%h exp=0011", dac_val); end
        total++; if (fifo_level !== 5'd7) begin bad++; $display("FAIL ur_resume_level got=%0d exp=7", fifo_level); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 9; i++) push_word(16'h0019 + 16'(i));
        total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", fifo_level); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_s_ready got=%b exp=0", s_ready); end
        push_word(16'hDEAD);
        total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_reject got=%0d exp=16", fifo_level); end
        req();
        total++; if (dac_val !== 16'h0012) begin bad++; $display("FAIL full_pop_val got=%h exp=0012", dac_val); end
        total++; if (fifo_level !== 5'd15) begin bad++; $display("FAIL full_pop_level got=%0d exp=15", fifo_level); end
        s_valid = 1'b1; s_data = 16'h0022; val_req = 1'b1;
        tick();
        s_valid = 1'b0; val_req = 1'b0;
        total++; if (dac_val !== 16'h0013) begin bad++; $display("FAIL both_val got=%h exp=0013", dac_val); end
        total++; if (fifo_level !== 5'd15) begin bad++; $display("FAIL both_level got=%0d exp=15", fifo_level); end
    endtask

    task automatic test_disable();
        enable = 1'b0;
        tick();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL dis_running got=%b exp=0", running); end
        total++; if (dac_val !== 16'h0013) begin bad++; $display("FAIL dis_hold got=%h exp=0013", dac_val); end
        tick();
        total++; if (dac_val !== 16'h0013) begin bad++; $display("FAIL dis_hold2 got=%h exp=0013", dac_val); end
        req();
        total++; if (dac_val !== 16'h8000) begin bad++; $display("FAIL dis_idle_val got=%h exp=8000", dac_val); end
        total++; if (fifo_level !== 5'd15) begin bad++; $display("FAIL dis_retain got=%0d exp=15", fifo_level); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) push_word(16'h0031 + 16'(i));
        total++; if (running !== 1'b1) begin bad++; $display("FAIL fl_running got=%b exp=1", running); end
        total++; if (fifo_level !== 5'd10) begin bad++; $display("FAIL fl_pre_level got=%0d exp=10", fifo_level); end
        flush = 1'b1; s_valid = 1'b1; s_data = 16'hBEEF;
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fl_s_ready got=%b exp=0", s_ready); end
        tick();
        flush = 1'b0; s_valid = 1'b0;
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL fl_level got=%0d exp=0", fifo_level); end
        total++; if (running !== 1'b1) begin bad++; $display("FAIL fl_state got=%b exp=1", running); end
        req();
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL fl_underrun got=%b exp=1", underrun); end
        total++; if (underrun_cnt !== 16'd2) begin bad++; $display("FAIL fl_cnt got=%0d exp=2", underrun_cnt); end
        total++; if (dac_val !== 16'h8000) begin bad++; $display("FAIL fl_hold got=%h exp=8000", dac_val); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) push_word(16'h0041 + 16'(i));
        tick();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL b2b_running got=%b exp=1", running); end
        val_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (dac_val !== 16'h0041 + 16'(i)) begin bad++; $display("FAIL b2b_val[%0d] got=%h exp=%h", i, dac_val, 16'h0041 + 16'(i)); end
            total++; if (fifo_level !== 5'(7 - i)) begin bad++; $display("FAIL b2b_level[%0d] got=%0d exp=%0d", i, fifo_level, 7 - i); end
        end
        val_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL rm_level got=%0d exp=0", fifo_level); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL rm_cnt got=%0d exp=0", underrun_cnt); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL rm_running got=%b exp=0", running); end
        total++; if (dac_val !== 16'h8000) begin bad++; $display("FAIL rm_dac_val got=%h exp=8000", dac_val); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_enable_no_data();
        test_prime_run();
        test_underrun();
        test_full();
        test_disable();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
